// File: rtl/cordic_sincos.sv
// Iterative rotation-mode CORDIC: one Q2.13 angle in, Q1.14 sine and cosine out.
// Start/done pulse handshake, one computation in flight.
module cordic_sincos #(
    parameter int ITERATIONS = 12
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               sc_start,
    input  logic signed [15:0] sc_angle,
    output logic               sc_busy,
    output logic               sc_done,
    output logic signed [15:0] sc_sin,
    output logic signed [15:0] sc_cos
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_PRE  = 2'd1;
    localparam logic [1:0] S_ITER = 2'd2;
    localparam logic [1:0] S_POST = 2'd3;

    localparam logic [3:0]   LAST_ITER = 4'(ITERATIONS - 1);
    localparam logic signed [23:0] ANG_PI     = 24'sd25736;
    localparam logic signed [23:0] ANG_HALFPI = 24'sd12868;
    localparam logic signed [23:0] K_GAIN     = 24'sd9949;
    localparam logic signed [23:0] OUT_MAX    = 24'sd16384;

    logic [1:0]          state;
    logic signed [23:0]  x, y, z;
    logic                flip;
    logic [3:0]          iter;

    logic signed [23:0]  ang_ext, ang_sat;
    logic signed [23:0]  z_fold;
    logic                flip_fold;
    logic signed [23:0]  x_sh, y_sh, atan_i;
    logic signed [23:0]  x_rot, y_rot, z_rot;
    logic signed [23:0]  c_full, s_full, c_sat, s_sat;

    function automatic logic signed [23:0] atan_lut(input logic [3:0] idx);
        case (idx)
            4'd0:    atan_lut = 24'sd6434;
            4'd1:    atan_lut = 24'sd3798;
            4'd2:    atan_lut = 24'sd2007;
            4'd3:    atan_lut = 24'sd1019;
            4'd4:    atan_lut = 24'sd511;
            4'd5:    atan_lut = 24'sd256;
            4'd6:    atan_lut = 24'sd128;
            4'd7:    atan_lut = 24'sd64;
            4'd8:    atan_lut = 24'sd32;
            4'd9:    atan_lut = 24'sd16;
            4'd10:   atan_lut = 24'sd8;
            4'd11:   atan_lut = 24'sd4;
            4'd12:   atan_lut = 24'sd2;
            4'd13:   atan_lut = 24'sd1;
            default: atan_lut = '0;
        endcase
    endfunction

    function automatic logic signed [23:0] sat_unit(input logic signed [23:0] v);
        if (v > OUT_MAX)
            sat_unit = OUT_MAX;
        else if (v < -OUT_MAX)
            sat_unit = -OUT_MAX;
        else
            sat_unit = v;
    endfunction

    // Angle saturation at acceptance; the saturated angle is parked in z until PRE folds it
    always_comb begin
        ang_ext = {{8{sc_angle[15]}}, sc_angle};
        if (ang_ext > ANG_PI)
            ang_sat = ANG_PI;
        else if (ang_ext < -ANG_PI)
            ang_sat = -ANG_PI;
        else
            ang_sat = ang_ext;
    end

    // Fold outer quadrants onto [-pi/2, pi/2]; negate the result at the end
    always_comb begin
        if (z > ANG_HALFPI) begin
            z_fold    = z - ANG_PI;
            flip_fold = 1'b1;
        end else if (z < -ANG_HALFPI) begin
            z_fold    = z + ANG_PI;
            flip_fold = 1'b1;
        end else begin
            z_fold    = z;
            flip_fold = 1'b0;
        end
    end

    always_comb begin
        x_sh   = x >>> iter;
        y_sh   = y >>> iter;
        atan_i = atan_lut(iter);
        if (!z[23]) begin
            x_rot = x - y_sh;
            y_rot = y + x_sh;
            z_rot = z - atan_i;
        end else begin
            x_rot = x + y_sh;
            y_rot = y - x_sh;
            z_rot = z + atan_i;
        end
    end

    always_comb begin
        c_full = flip ? -x : x;
        s_full = flip ? -y : y;
        c_sat  = sat_unit(c_full);
        s_sat  = sat_unit(s_full);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            x       <= '0;
            y       <= '0;
            z       <= '0;
            flip    <= 1'b0;
            iter    <= '0;
            sc_busy <= 1'b0;
            sc_done <= 1'b0;
            sc_sin  <= '0;
            sc_cos  <= '0;
        end else begin
            sc_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (sc_start) begin
                        z       <= ang_sat;
                        sc_busy <= 1'b1;
                        state   <= S_PRE;
                    end
                end
                S_PRE: begin
                    z     <= z_fold;
                    flip  <= flip_fold;
                    x     <= K_GAIN;
                    y     <= '0;
                    iter  <= '0;
                    state <= S_ITER;
                end
                S_ITER: begin
                    x    <= x_rot;
                    y    <= y_rot;
                    z    <= z_rot;
                    iter <= iter + 4'd1;
                    if (iter == LAST_ITER)
                        state <= S_POST;
                end
                S_POST: begin
                    sc_cos  <= c_sat[15:0];
                    sc_sin  <= s_sat[15:0];
                    sc_done <= 1'b1;
                    sc_busy <= 1'b0;
                    state   <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/cordic_sincos.md
Name: cordic_sincos

Overview:
- Iterative rotation-mode CORDIC engine. Takes one angle and returns its sine and cosine.
- Inverse companion of the vectoring-mode angle path: that path turns a vector into an angle; this block turns an angle back into a unit vector.
- Used by the attitude/mixer logic to rotate body-frame vectors by roll, pitch and yaw.
- Start/done pulse handshake; one computation in flight at a time.

Parameters:
- ITERATIONS, 12, number of micro-rotations. Legal range 8..14.
- ATAN_TABLE: internal constant, not overridable. Values atan(2^-i) in Q2.13 radians, i = 0..13: 6434, 3798, 2007, 1019, 511, 256, 128, 64, 32, 16, 8, 4, 2, 1.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset: asynchronous, active-low.
- sc_start  in  1  one-cycle request. Sampled only in IDLE.
- sc_angle  in  16  signed angle, Q2.13 radians (8192 = 1.0 rad). Nominal range ±25736 (±π).
- sc_busy  out  1  high from the accepting edge until the edge that asserts sc_done.
- sc_done  out  1  one-cycle pulse; results valid.
- sc_sin  out  16  signed sine, Q1.14 (16384 = 1.0).
- sc_cos  out  16  signed cosine, Q1.14.

Behaviour:
- Reset: state = IDLE; sc_busy, sc_done, sc_sin, sc_cos = 0; internal x, y, z = 0. Reset asserted mid-operation aborts the computation; no done pulse is produced.
- Datapath: x, y, z are 24-bit signed. sc_angle is sign-extended to 24 bits.
- IDLE:
  - if sc_start: latch sc_angle, saturating it to [-25736, 25736]; sc_busy <= 1; go to PRE.
  - otherwise stay in IDLE.
- PRE (1 cycle), quadrant fold:
  - if a > 12868: z <= a - 25736, flip <= 1.
  - else if a < -12868: z <= a + 25736, flip <= 1.
  - else: z <= a, flip <= 0.
  - Always: x <= 9949 (K = 0.607253 × 2^14, gain precompensated); y <= 0; i <= 0. Go to ITER.
- ITER (exactly ITERATIONS cycles), each cycle:
  - d = +1 if z >= 0, else -1.
  - x <= x - d·(y >>> i); y <= y + d·(x >>> i); z <= z - d·ATAN_TABLE[i]. All shifts arithmetic. Old x and y are used on both right-hand sides.
  - i <= i + 1. When i == ITERATIONS-1, go to POST.
- POST (1 cycle):
  - if flip: c = -x, s = -y; else c = x, s = y.
  - Saturate each to [-16384, 16384] and truncate to 16 bits.
  - sc_cos <= c; sc_sin <= s; sc_done <= 1; sc_busy <= 0; go to IDLE.
- Done clears on the next edge. sc_sin and sc_cos hold until the next sc_done.
- Latency: start sampled at edge E0; sc_done rises at edge E0 + ITERATIONS + 2 (14 cycles at default).
- sc_start while busy (PRE, ITER, POST) is ignored and not queued.
- sc_start in the cycle where sc_done is high is accepted, since the state is IDLE.
- sc_angle is captured only at acceptance; later changes have no effect on the result.
- Accuracy at ITERATIONS = 12: |error| ≤ 12 LSB on both outputs over the full input range.

Test Plan:
- Reset, then sc_angle = 0 with one-cycle start -> sc_busy high 14 cycles; sc_done one cycle at E0+14; sc_cos = 16384 ±12, sc_sin = 0 ±12.
- sc_angle = 6434 (π/4) -> sc_sin = 11585 ±12, sc_cos = 11585 ±12. sc_angle = -4289 (-π/6) -> sc_sin = -8192 ±12, sc_cos = 14189 ±12.
- Quadrant fold:
  - sc_angle = 25736 (π) -> sc_cos = -16384 ±12, sc_sin = 0 ±12.
  - sc_angle = -12868 -> sc_sin = -16384 ±12, sc_cos = 0 ±12.
  - sc_angle = 19302 (3π/4) -> sc_sin = 11585, sc_cos = -11585, each ±12.
- Out-of-range input: sc_angle = 32000 -> same result as 25736. sc_angle = -32768 -> same result as -25736.
- Handshake:
  - Pulse start again at E0+3 with a different angle -> ignored; result matches the first angle.
  - Start held high through done -> second computation accepted on the done cycle; its done arrives 14 cycles later.
- Reset at E0+6 -> all outputs 0; no sc_done. A new start after release completes normally.
